// File: rtl/exponent_accelerator_sw_capture.sv
// Avalon-MM switch/key input port: synchronises and optionally debounces the pins.
// It latches edges into a write-1-to-clear register and raises a maskable level irq.
module exponent_accelerator_sw_capture #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] db_prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [31:0]      rd_mux;
    logic             rd_en;
    logic             wr_mask;
    logic             wr_edge;
    logic             unused_wdata;

    // Two-flop synchroniser; the pins are asynchronous to clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            assign db = s2;
        end else begin : g_debounce
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt [WIDTH];
            logic [WIDTH-1:0] db_q;

            // A bit only follows s2 after disagreeing for DEBOUNCE_CYCLES clocks in a row.
            always_ff @(posedge clk) begin
                if (reset) begin
                    db_q <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (s2[i] == db_q[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            db_q[i] <= s2[i];
                            cnt[i]  <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                end
            end

            assign db = db_q;
        end
    endgenerate

    always_comb begin
        rise = db & ~db_prev;
        fall = ~db & db_prev;
        case (EDGE_TYPE)
            0:       evt = rise;
            1:       evt = fall;
            default: evt = rise | fall;
        endcase
    end

    assign rd_en        = chipselect & ~read_n;
    assign wr_mask      = chipselect & ~write_n & (address == ADDR_MASK);
    assign wr_edge      = chipselect & ~write_n & (address == ADDR_EDGE);
    assign clr          = wr_edge ? writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^writedata;

    // A fresh event outranks a clear landing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_prev      <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
        end else begin
            db_prev      <= db;
            edge_capture <= evt | (edge_capture & ~clr);
            if (wr_mask) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = db;
            ADDR_RSVD: rd_mux            = '0;
            ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
            default:   rd_mux            = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule
